// File: rtl/mux4_4bit.sv
`default_nettype none
// ============================================================================
// Module   : mux4_4bit
// Purpose  : 4-to-1 WIDTH-bit multiplexer (decoder + per-bit AND-OR tree)
//            with a combinational result and a registered copy.
// Revision : 1.0
// ============================================================================
module mux4_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [3:0]       dec;
  logic [WIDTH-1:0] sel;

  assign dec[0] = ~s[1] & ~s[0];
  assign dec[1] = ~s[1] &  s[0];
  assign dec[2] =  s[1] & ~s[0];
  assign dec[3] =  s[1] &  s[0];

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic and_or;
      logic consensus;

      assign and_or = (dec[0] & in0[i]) | (dec[1] & in1[i])
                    | (dec[2] & in2[i]) | (dec[3] & in3[i]);

      // Logically redundant terms: when a select bit is unknown, they keep the
      // result known wherever all remaining candidates agree on 1.
      assign consensus = (in0[i] & in1[i] & ~s[1]) | (in2[i] & in3[i] & s[1])
                       | (in0[i] & in2[i] & ~s[0]) | (in1[i] & in3[i] & s[0])
                       | (in0[i] & in1[i] & in2[i] & in3[i]);

      assign sel[i] = and_or | consensus;
    end
  endgenerate

  assign out = sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= sel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux4_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_4bit
// Purpose  : Self-checking bench for mux4_4bit using expectation queues.
// Revision : 1.0
// ============================================================================
module tb_mux4_4bit;

  logic       clk;
  logic       rst;
  logic [1:0] s;
  logic [3:0] in0, in1, in2, in3;
  logic [3:0] out, out_q;

  int vectors;
  int miscompares;

  logic [3:0] sb_out[$];
  logic [3:0] sb_q[$];
  logic [3:0] exp_v;
  logic [3:0] exp_out;
  bit         soak_on;

  mux4_4bit #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .s    (s),
    .in0  (in0),
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .out  (out),
    .out_q(out_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] model(input logic [1:0] sv, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c,
                                       input logic [3:0] d);
    case (sv)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  // Registered-output scoreboard during soak: expectation taken at the edge
  // from the bench's own model value, checked half a cycle later.
  always @(posedge clk) begin
    if (soak_on) sb_q.push_back(exp_out);
  end

  always @(negedge clk) begin
    if (soak_on && sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      vectors++;
      if (out_q !== exp_v) begin
        miscompares++;
        $display("FAIL soak_out_q t=%0t: out_q=%h expected %h", $time, out_q, exp_v);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; s = 2'd0; in0 = 4'h0; in1 = 4'h0; in2 = 4'h0; in3 = 4'h0;
    repeat (2) @(posedge clk);
    sb_q.push_back(4'h0);
    #1;
    exp_v = sb_q.pop_front();
    vectors++;
    if (out_q !== exp_v) begin
      miscompares++;
      $display("FAIL reset_out_q: out_q=%h expected %h", out_q, exp_v);
    end
  endtask

  task automatic test_select();
    @(negedge clk);
    in0 = 4'h1; in1 = 4'h2; in2 = 4'h4; in3 = 4'h8;
    for (int k = 0; k < 4; k++) begin
      s = k[1:0];
      sb_out.push_back(4'h1 << k);
      #1;
      exp_v = sb_out.pop_front();
      vectors++;
      if (out !== exp_v) begin
        miscompares++;
        $display("FAIL select s=%0d: out=%h expected %h", k, out, exp_v);
      end
    end
  endtask

  task automatic test_isolation();
    @(negedge clk);
    s = 2'b10; in2 = 4'hA;
    for (int k = 0; k < 8; k++) begin
      in0 = 4'($urandom); in1 = 4'($urandom); in3 = 4'($urandom);
      sb_out.push_back(4'hA);
      #1;
      exp_v = sb_out.pop_front();
      vectors++;
      if (out !== exp_v) begin
        miscompares++;
        $display("FAIL isolation step %0d: out=%h expected %h", k, out, exp_v);
      end
    end
  endtask

  task automatic test_tracking();
    logic [3:0] seq [3];
    seq[0] = 4'h3; seq[1] = 4'hC; seq[2] = 4'h5;
    @(negedge clk);
    s = 2'b01;
    for (int k = 0; k < 3; k++) begin
      in1 = seq[k];
      sb_out.push_back(seq[k]);
      #1;
      exp_v = sb_out.pop_front();
      vectors++;
      if (out !== exp_v) begin
        miscompares++;
        $display("FAIL tracking step %0d: out=%h expected %h", k, out, exp_v);
      end
    end
  endtask

  task automatic test_register();
    @(negedge clk);
    rst = 1'b0; s = 2'b11; in3 = 4'h7;
    @(posedge clk);
    sb_q.push_back(4'h7);
    #1;
    exp_v = sb_q.pop_front();
    vectors++;
    if (out_q !== exp_v) begin
      miscompares++;
      $display("FAIL reg_load: out_q=%h expected %h", out_q, exp_v);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    sb_q.push_back(4'h0);
    sb_out.push_back(4'h7);
    #1;
    exp_v = sb_q.pop_front();
    vectors++;
    if (out_q !== exp_v) begin
      miscompares++;
      $display("FAIL reg_midreset: out_q=%h expected %h", out_q, exp_v);
    end
    exp_v = sb_out.pop_front();
    vectors++;
    if (out !== exp_v) begin
      miscompares++;
      $display("FAIL reset_no_effect_on_out: out=%h expected %h", out, exp_v);
    end
    @(negedge clk);
    rst = 1'b0; in3 = 4'hE;
    @(posedge clk);
    sb_q.push_back(4'hE);
    #1;
    exp_v = sb_q.pop_front();
    vectors++;
    if (out_q !== exp_v) begin
      miscompares++;
      $display("FAIL reg_release: out_q=%h expected %h", out_q, exp_v);
    end
  endtask

  // Changes land only on even ticks or ticks 0/5 mod 10 after a start 2 mod 10,
  // so they never coincide with a rising edge (5 mod 10).
  task automatic test_soak();
    bit changed;
    @(negedge clk);
    #2;
    exp_out = model(s, in0, in1, in2, in3);
    soak_on = 1'b1;
    for (int t = 0; t < 500; t++) begin
      changed = 1'b0;
      if (t % 15 == 0) begin s   = 2'($urandom); changed = 1'b1; end
      if (t % 8  == 0) begin in0 = 4'($urandom); changed = 1'b1; end
      if (t % 10 == 0) begin in1 = 4'($urandom); changed = 1'b1; end
      if (t % 12 == 0) begin in2 = 4'($urandom); changed = 1'b1; end
      if (t % 18 == 0) begin in3 = 4'($urandom); changed = 1'b1; end
      if (changed) begin
        exp_out = model(s, in0, in1, in2, in3);
        sb_out.push_back(exp_out);
      end
      #1;
      if (changed) begin
        exp_v = sb_out.pop_front();
        vectors++;
        if (out !== exp_v) begin
          miscompares++;
          $display("FAIL soak_out t=%0t s=%0d: out=%h expected %h", $time, s, out, exp_v);
        end
      end
    end
    soak_on = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    soak_on = 1'b0;
    exp_out = 4'h0;
    test_reset();
    test_select();
    test_isolation();
    test_tracking();
    test_register();
    test_soak();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
